// File: rtl/adc_spi_responder.sv
// SPI responder emulating a serial ADC: decodes start/SGL/ODD on din, then returns
// a null bit followed by a DATA_W-bit result, MSB first, on doutb.
module adc_spi_responder #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstc_n,
  input  logic              sclk,
  input  logic              cs,
  input  logic              din,
  input  logic [DATA_W-1:0] ch0_data,
  input  logic [DATA_W-1:0] ch1_data,
  output logic              doutb,
  output logic              doutb_oe,
  output logic              conv_done,
  output logic              frame_err,
  output logic              cmd_sgl,
  output logic              cmd_odd
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    NULLB = 3'd2,
    DATA  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] din_sync;
  logic               sclk_prev;
  logic               sclk_synced;
  logic               cs_synced;
  logic               din_synced;
  logic               sclk_rise;
  logic               sclk_fall;
  logic [DATA_W-1:0]  shreg;
  logic [CNT_W-1:0]   cnt;
  logic               sgl_bit;

  // Single-ended result or clamped difference; the subtraction keeps a borrow bit.
  function automatic logic [DATA_W-1:0] compute_result(
    input logic              sgl,
    input logic              odd,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] res;
    if (sgl) begin
      res = odd ? b : a;
    end else begin
      diff = odd ? ({1'b0, b} - {1'b0, a}) : ({1'b0, a} - {1'b0, b});
      res  = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
    end
    return res;
  endfunction

  assign sclk_synced = sclk_sync[SYNC_STAGES-1];
  assign cs_synced   = cs_sync[SYNC_STAGES-1];
  assign din_synced  = din_sync[SYNC_STAGES-1];
  assign sclk_rise   = sclk_synced & ~sclk_prev;
  assign sclk_fall   = ~sclk_synced & sclk_prev;

  // Input synchronisers; cs resets to the inactive level so the bus stays released.
  always_ff @(posedge clk or negedge rstc_n) begin
    if (!rstc_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      din_sync  <= '0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      din_sync  <= {din_sync[SYNC_STAGES-2:0], din};
      sclk_prev <= sclk_synced;
    end
  end

  // Frame state machine with registered outputs.
  always_ff @(posedge clk or negedge rstc_n) begin
    if (!rstc_n) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      sgl_bit   <= 1'b0;
      doutb     <= 1'b0;
      doutb_oe  <= 1'b0;
      conv_done <= 1'b0;
      frame_err <= 1'b0;
      cmd_sgl   <= 1'b0;
      cmd_odd   <= 1'b0;
    end else if (cs_synced) begin
      // Deselect wins over any coincident sclk edge.
      state     <= IDLE;
      doutb     <= 1'b0;
      doutb_oe  <= 1'b0;
      conv_done <= 1'b0;
      frame_err <= (state != IDLE) && (state != DONE);
    end else begin
      doutb_oe  <= 1'b1;
      conv_done <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (sclk_rise && din_synced) begin
            state <= CMD;
            cnt   <= '0;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            if (cnt == '0) begin
              sgl_bit <= din_synced;
              cnt     <= CNT_W'(1);
            end else begin
              cmd_sgl <= sgl_bit;
              cmd_odd <= din_synced;
              shreg   <= compute_result(sgl_bit, din_synced, ch0_data, ch1_data);
              state   <= NULLB;
            end
          end
        end
        NULLB: begin
          if (sclk_fall) begin
            doutb <= 1'b0;
            cnt   <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          if (sclk_fall && (cnt != CNT_W'(DATA_W))) begin
            doutb <= shreg[DATA_W-1];
            shreg <= {shreg[DATA_W-2:0], 1'b0};
            cnt   <= cnt + CNT_W'(1);
          end else if (sclk_rise && (cnt == CNT_W'(DATA_W))) begin
            // Initiator has just sampled the LSB.
            conv_done <= 1'b1;
            doutb     <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          doutb <= 1'b0;
        end
        default: begin
          state <= IDLE;
          doutb <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: directed frame table plus random frames, checked
// against an arithmetic model of the ADC result.
module tb_adc_spi_responder;

  localparam int DATA_W = 8;
  localparam int H      = 6;  // sclk half period in clk cycles

  logic             clk = 1'b0;
  logic             rstc_n = 1'b0;
  logic             sclk = 1'b0;
  logic             cs = 1'b1;
  logic             din = 1'b0;
  logic [DATA_W-1:0] ch0_data = '0;
  logic [DATA_W-1:0] ch1_data = '0;
  logic             doutb, doutb_oe, conv_done, frame_err, cmd_sgl, cmd_odd;

  int nchk = 0;
  int nerr = 0;
  int nconv = 0;
  int nferr = 0;

  adc_spi_responder #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rstc_n(rstc_n), .sclk(sclk), .cs(cs), .din(din),
    .ch0_data(ch0_data), .ch1_data(ch1_data),
    .doutb(doutb), .doutb_oe(doutb_oe), .conv_done(conv_done),
    .frame_err(frame_err), .cmd_sgl(cmd_sgl), .cmd_odd(cmd_odd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (conv_done === 1'b1) nconv++;
    if (frame_err === 1'b1) nferr++;
  end

  typedef struct {
    string name;
    int    lz;       // leading zeros before start bit
    int    sgl;
    int    odd;
    int    c0;
    int    c1;
    int    c0_late;  // new ch0 after the ODD rise, -1 = unchanged
    int    mode;     // 0 full frame, 1 cs abort, 2 reset pulse
    int    stop_at;  // bits received (null = 0) before abort/reset
  } vec_t;

  vec_t vecs[10];

  function automatic int model(int sgl, int odd, int a, int b);
    int d;
    if (sgl != 0) return (odd != 0) ? b : a;
    d = (odd != 0) ? (b - a) : (a - b);
    return (d < 0) ? 0 : d;
  endfunction

  task automatic chk(input string vn, input string what, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s/%s: got %0h, expected %0h", vn, what, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_frame(input vec_t v);
    logic [DATA_W:0] rx;
    int bit_v, e0, f0, expv;
    rx   = '0;
    expv = model(v.sgl, v.odd, v.c0, v.c1);
    ch0_data = DATA_W'(v.c0);
    ch1_data = DATA_W'(v.c1);
    sclk = 1'b0;
    cs   = 1'b0;
    wclk(H);
    e0 = nconv;
    f0 = nferr;
    chk(v.name, "oe_active", doutb_oe, 1);
    for (int i = 0; i < v.lz + 3; i++) begin
      if (i < v.lz) bit_v = 0;
      else if (i == v.lz) bit_v = 1;
      else if (i == v.lz + 1) bit_v = v.sgl;
      else bit_v = v.odd;
      sclk = 1'b0;
      din  = bit_v[0];
      wclk(H);
      sclk = 1'b1;
      wclk(H);
    end
    if (v.c0_late >= 0) ch0_data = DATA_W'(v.c0_late);
    chk(v.name, "cmd_sgl", cmd_sgl, v.sgl);
    chk(v.name, "cmd_odd", cmd_odd, v.odd);
    for (int i = 0; i <= DATA_W; i++) begin
      sclk = 1'b0;
      wclk(H);
      rx = {rx[DATA_W-1:0], doutb};
      sclk = 1'b1;
      wclk(H);
      if (v.mode != 0 && i == v.stop_at) break;
    end
    if (v.mode == 1) begin
      cs = 1'b1;
      wclk(H);
      chk(v.name, "abort_ferr", nferr - f0, 1);
      chk(v.name, "abort_oe", doutb_oe, 0);
      chk(v.name, "abort_doutb", doutb, 0);
      chk(v.name, "abort_conv", nconv - e0, 0);
      sclk = 1'b0;
    end else if (v.mode == 2) begin
      wclk(1);
      rstc_n = 1'b0;
      cs     = 1'b1;
      sclk   = 1'b0;
      #1;
      chk(v.name, "rst_outs", {doutb, doutb_oe, conv_done, frame_err, cmd_sgl, cmd_odd}, 0);
      wclk(H);
      rstc_n = 1'b1;
      wclk(H);
      chk(v.name, "rst_pulses", (nconv - e0) + (nferr - f0), 0);
      chk(v.name, "rst_after", {doutb, doutb_oe, cmd_sgl, cmd_odd}, 0);
    end else begin
      chk(v.name, "null_bit", rx[DATA_W], 0);
      chk(v.name, "result", rx[DATA_W-1:0], expv);
      chk(v.name, "conv_once", nconv - e0, 1);
      sclk = 1'b0;
      wclk(H);
      cs = 1'b1;
      wclk(H);
      chk(v.name, "idle_oe", doutb_oe, 0);
      chk(v.name, "idle_doutb", doutb, 0);
      chk(v.name, "no_ferr", nferr - f0, 0);
      chk(v.name, "conv_total", nconv - e0, 1);
    end
    wclk(H);
  endtask

  initial begin
    vec_t rv;
    vecs[0] = '{"sgl_ch0",   0, 1, 0, 'hA5, 'h00, -1,   0, 0};
    vecs[1] = '{"sgl_ch1",   0, 1, 1, 'h11, 'h3C, 'hFF, 0, 0};
    vecs[2] = '{"diff_pos",  0, 0, 0, 'h30, 'h10, -1,   0, 0};
    vecs[3] = '{"diff_clmp", 0, 0, 1, 'h30, 'h10, -1,   0, 0};
    vecs[4] = '{"diff_full", 0, 0, 0, 'hFF, 'h00, -1,   0, 0};
    vecs[5] = '{"lead_zero", 3, 1, 0, 'hA5, 'h5A, -1,   0, 0};
    vecs[6] = '{"cs_abort",  0, 1, 0, 'hA5, 'h00, -1,   1, 4};
    vecs[7] = '{"post_abrt", 0, 1, 0, 'hA5, 'h00, -1,   0, 0};
    vecs[8] = '{"rst_mid",   0, 1, 1, 'h00, 'hC3, -1,   2, 3};
    vecs[9] = '{"post_rst",  1, 0, 1, 'h20, 'h7F, -1,   0, 0};

    #1;
    chk("reset", "outs_in_rst", {doutb, doutb_oe, conv_done, frame_err, cmd_sgl, cmd_odd}, 0);
    wclk(4);
    rstc_n = 1'b1;
    wclk(6);
    chk("reset", "outs_idle", {doutb, doutb_oe, conv_done, frame_err, cmd_sgl, cmd_odd}, 0);

    for (int k = 0; k < 10; k++) run_frame(vecs[k]);

    // Explicit bit pattern for test 1: null then 0xA5 MSB first.
    chk("sgl_ch0", "pattern", {1'b0, 8'hA5}, 9'b010100101);

    for (int k = 0; k < 16; k++) begin
      rv.name    = "random";
      rv.lz      = int'($urandom_range(0, 2));
      rv.sgl     = int'($urandom_range(0, 1));
      rv.odd     = int'($urandom_range(0, 1));
      rv.c0      = int'($urandom_range(0, 255));
      rv.c1      = int'($urandom_range(0, 255));
      rv.c0_late = (k % 3 == 0) ? int'($urandom_range(0, 255)) : -1;
      rv.mode    = 0;
      rv.stop_at = 0;
      run_frame(rv);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
